// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32_pkg
// Brief    : Shared hazard-control types and constants for the RV32 core.
// Revision : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    localparam logic [1:0] LOAD_RESULT_SRC = 2'b01;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic [0:0] {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic flush_d;
        logic flush_e;
        logic flush_m;
    } hazard_ctrl_t;

    localparam hazard_ctrl_t HAZARD_NONE = '0;

    // x0 is hardwired to zero, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_hazard_mc_fsm.sv
`default_nettype none
// ============================================================================
// Module   : rv32_hazard_mc_fsm
// Brief    : Start/done sequencer and timeout watchdog for multi-cycle E ops.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_hazard_mc_fsm #(
    parameter int MC_TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic mc_op_e_i,
    input  logic pc_source_e_i,
    input  logic mc_done_i,
    output logic mc_active_o,
    output logic mc_hold_o,
    output logic mc_flush_m_o,
    output logic mc_start_o,
    output logic mc_busy_o,
    output logic mc_timeout_o
);
    import rv32_pkg::*;

    localparam int                 c_cnt_w   = $clog2(MC_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MC_TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    mc_state_e          r_state;
    mc_state_e          w_state_nxt;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_count_nxt;
    logic               r_timeout;
    logic               w_timeout_nxt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= MC_IDLE;
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_timeout_nxt = r_timeout;
        mc_active_o   = 1'b0;
        mc_hold_o     = 1'b0;
        mc_flush_m_o  = 1'b0;
        mc_start_o    = 1'b0;
        case (r_state)
            MC_IDLE: begin
                // A taken branch squashes the op before it is launched.
                if (mc_op_e_i && !pc_source_e_i) begin
                    mc_active_o  = 1'b1;
                    mc_hold_o    = 1'b1;
                    mc_flush_m_o = 1'b1;
                    mc_start_o   = 1'b1;
                    w_count_nxt  = '0;
                    w_state_nxt  = MC_BUSY;
                end
            end
            MC_BUSY: begin
                mc_active_o = 1'b1;
                w_count_nxt = r_count + c_cnt_one;
                if (mc_done_i) begin
                    w_state_nxt = MC_IDLE;
                end else if (r_count == c_cnt_max) begin
                    // Abort: let the pipe move on, but bubble the stale result.
                    mc_flush_m_o  = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = MC_IDLE;
                end else begin
                    mc_hold_o    = 1'b1;
                    mc_flush_m_o = 1'b1;
                end
            end
            default: begin
                w_state_nxt = MC_IDLE;
            end
        endcase
    end

    assign mc_busy_o    = (r_state == MC_BUSY);
    assign mc_timeout_o = r_timeout;

endmodule
`default_nettype wire

// File: rtl/rv32_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv32_hazard_ctrl
// Brief    : Forwarding selects, load-use stalls, flushes and multi-cycle ops.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_hazard_ctrl #(
    parameter int         MC_TIMEOUT      = 64,
    parameter logic [1:0] LOAD_RESULT_SRC = rv32_pkg::LOAD_RESULT_SRC
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [4:0] rs1_d_i,
    input  logic [4:0] rs2_d_i,
    input  logic [4:0] rs1_e_i,
    input  logic [4:0] rs2_e_i,
    input  logic [4:0] rd_e_i,
    input  logic [1:0] result_source_e_i,
    input  logic [4:0] rd_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_m_i,
    input  logic       reg_write_w_i,
    input  logic       pc_source_e_i,
    input  logic       mc_op_e_i,
    input  logic       mc_done_i,
    output logic [1:0] forward_a_o,
    output logic [1:0] forward_b_o,
    output logic       stall_f_o,
    output logic       stall_d_o,
    output logic       stall_e_o,
    output logic       flush_d_o,
    output logic       flush_e_o,
    output logic       flush_m_o,
    output logic       mc_start_o,
    output logic       mc_busy_o,
    output logic       mc_timeout_o
);
    import rv32_pkg::*;

    // The younger producer in M shadows an older write of the same register in W.
    function automatic fwd_sel_e fwd_select(
        input logic [4:0] rs_e,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        if (wr_m && reg_match(rd_m, rs_e)) begin
            return FWD_M;
        end else if (wr_w && reg_match(rd_w, rs_e)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    fwd_sel_e     w_fwd_a;
    fwd_sel_e     w_fwd_b;
    logic         w_lw_stall;
    hazard_ctrl_t w_hz;
    logic         w_mc_active;
    logic         w_mc_hold;
    logic         w_mc_flush_m;
    logic         w_mc_start;

    assign w_fwd_a = fwd_select(rs1_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
    assign w_fwd_b = fwd_select(rs2_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);

    assign w_lw_stall = (result_source_e_i == LOAD_RESULT_SRC) &&
                        (reg_match(rd_e_i, rs1_d_i) || reg_match(rd_e_i, rs2_d_i));

    rv32_hazard_mc_fsm #(
        .MC_TIMEOUT (MC_TIMEOUT)
    ) u_mc_fsm (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .mc_op_e_i     (mc_op_e_i),
        .pc_source_e_i (pc_source_e_i),
        .mc_done_i     (mc_done_i),
        .mc_active_o   (w_mc_active),
        .mc_hold_o     (w_mc_hold),
        .mc_flush_m_o  (w_mc_flush_m),
        .mc_start_o    (w_mc_start),
        .mc_busy_o     (mc_busy_o),
        .mc_timeout_o  (mc_timeout_o)
    );

    // While a multi-cycle op owns E it is neither a load nor a branch, so the
    // sequencer alone decides the pipeline enables.
    always_comb begin
        w_hz = HAZARD_NONE;
        if (w_mc_active) begin
            w_hz.stall_f = w_mc_hold;
            w_hz.stall_d = w_mc_hold;
            w_hz.stall_e = w_mc_hold;
            w_hz.flush_m = w_mc_flush_m;
        end else begin
            if (w_lw_stall) begin
                w_hz.stall_f = 1'b1;
                w_hz.stall_d = 1'b1;
                w_hz.flush_e = 1'b1;
            end
            if (pc_source_e_i) begin
                w_hz.flush_d = 1'b1;
                w_hz.flush_e = 1'b1;
                w_hz.stall_d = 1'b0;
            end
        end
        if (!rst_n_i) begin
            w_hz = HAZARD_NONE;
        end
    end

    assign forward_a_o = rst_n_i ? w_fwd_a : FWD_RF;
    assign forward_b_o = rst_n_i ? w_fwd_b : FWD_RF;
    assign stall_f_o   = w_hz.stall_f;
    assign stall_d_o   = w_hz.stall_d;
    assign stall_e_o   = w_hz.stall_e;
    assign flush_d_o   = w_hz.flush_d;
    assign flush_e_o   = w_hz.flush_e;
    assign flush_m_o   = w_hz.flush_m;
    assign mc_start_o  = rst_n_i & w_mc_start;

endmodule
`default_nettype wire

// File: tb/tb_rv32_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_hazard_ctrl
// Brief    : Self-checking bench: vector table, corner sequences, random + model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_hazard_ctrl;

    localparam int TB_TIMEOUT = 12;

    typedef struct packed {
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
        logic [1:0] res_src;
        logic [4:0] rd_m, rd_w;
        logic       wm, ww, pc, mc_op, done, rst_n;
    } in_t;

    typedef struct packed {
        logic [1:0] fwd_a, fwd_b;
        logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, start, busy, timeout;
    } out_t;

    typedef struct {
        string name;
        in_t   vin;
        out_t  vexp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0] res_src;
    logic       wm, ww, pc, mc_op, done;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, start, busy, timeout;

    int n_tests = 0;
    int n_fail  = 0;

    int m_busy_n;   // 0 when idle, else 1-based index of the current busy cycle
    bit m_to;

    always #5 clk = ~clk;

    rv32_hazard_ctrl #(
        .MC_TIMEOUT      (TB_TIMEOUT),
        .LOAD_RESULT_SRC (2'b01)
    ) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .rs1_d_i           (rs1_d),
        .rs2_d_i           (rs2_d),
        .rs1_e_i           (rs1_e),
        .rs2_e_i           (rs2_e),
        .rd_e_i            (rd_e),
        .result_source_e_i (res_src),
        .rd_m_i            (rd_m),
        .rd_w_i            (rd_w),
        .reg_write_m_i     (wm),
        .reg_write_w_i     (ww),
        .pc_source_e_i     (pc),
        .mc_op_e_i         (mc_op),
        .mc_done_i         (done),
        .forward_a_o       (fwd_a),
        .forward_b_o       (fwd_b),
        .stall_f_o         (stall_f),
        .stall_d_o         (stall_d),
        .stall_e_o         (stall_e),
        .flush_d_o         (flush_d),
        .flush_e_o         (flush_e),
        .flush_m_o         (flush_m),
        .mc_start_o        (start),
        .mc_busy_o         (busy),
        .mc_timeout_o      (timeout)
    );

    // bits = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, start, busy, timeout}
    function automatic out_t ex(input logic [1:0] fa, input logic [1:0] fb, input logic [8:0] bits);
        return out_t'({fa, fb, bits});
    endfunction

    function automatic logic [1:0] ref_fwd(input in_t i, input logic [4:0] rs);
        logic [4:0] dst  [2];
        logic       wr   [2];
        logic [1:0] code [2];
        dst[0] = i.rd_m; wr[0] = i.wm; code[0] = 2'b10;
        dst[1] = i.rd_w; wr[1] = i.ww; code[1] = 2'b01;
        if (rs == 5'd0) return 2'b00;
        for (int p = 0; p < 2; p++) begin
            if (wr[p] && dst[p] == rs) return code[p];
        end
        return 2'b00;
    endfunction

    function automatic out_t model_eval(input in_t i);
        out_t o;
        logic lw;
        o = '0;
        if (!i.rst_n) return o;
        o.fwd_a   = ref_fwd(i, i.rs1_e);
        o.fwd_b   = ref_fwd(i, i.rs2_e);
        o.timeout = m_to;
        if (m_busy_n != 0) begin
            o.busy = 1'b1;
            if (!i.done) begin
                if (m_busy_n > TB_TIMEOUT) begin
                    o.flush_m = 1'b1;
                end else begin
                    o.stall_f = 1'b1; o.stall_d = 1'b1; o.stall_e = 1'b1; o.flush_m = 1'b1;
                end
            end
        end else if (i.mc_op && !i.pc) begin
            o.start = 1'b1;
            o.stall_f = 1'b1; o.stall_d = 1'b1; o.stall_e = 1'b1; o.flush_m = 1'b1;
        end else begin
            lw = (i.res_src == 2'b01) && (i.rd_e != 5'd0) &&
                 ((i.rd_e == i.rs1_d) || (i.rd_e == i.rs2_d));
            o.stall_f = lw;
            o.stall_d = lw && !i.pc;
            o.flush_e = lw || i.pc;
            o.flush_d = i.pc;
        end
        return o;
    endfunction

    function automatic void model_step(input in_t i);
        if (!i.rst_n) begin
            m_busy_n = 0;
            m_to     = 1'b0;
        end else if (m_busy_n != 0) begin
            if (i.done) begin
                m_busy_n = 0;
            end else if (m_busy_n > TB_TIMEOUT) begin
                m_busy_n = 0;
                m_to     = 1'b1;
            end else begin
                m_busy_n = m_busy_n + 1;
            end
        end else if (i.mc_op && !i.pc) begin
            m_busy_n = 1;
        end
    endfunction

    function automatic in_t rand_in();
        in_t r;
        r.rs1_d   = 5'($urandom_range(0, 3));
        r.rs2_d   = 5'($urandom_range(0, 3));
        r.rs1_e   = 5'($urandom_range(0, 3));
        r.rs2_e   = 5'($urandom_range(0, 3));
        r.rd_e    = 5'($urandom_range(0, 3));
        r.res_src = 2'($urandom_range(0, 3));
        r.rd_m    = 5'($urandom_range(0, 3));
        r.rd_w    = 5'($urandom_range(0, 3));
        r.wm      = ($urandom_range(0, 1) == 1);
        r.ww      = ($urandom_range(0, 1) == 1);
        r.pc      = ($urandom_range(0, 5) == 0);
        r.mc_op   = ($urandom_range(0, 4) == 0);
        r.done    = ($urandom_range(0, 7) == 0);
        r.rst_n   = ($urandom_range(0, 199) != 0);
        return r;
    endfunction

    task automatic apply(input in_t i);
        rs1_d = i.rs1_d; rs2_d = i.rs2_d; rs1_e = i.rs1_e; rs2_e = i.rs2_e;
        rd_e = i.rd_e; res_src = i.res_src; rd_m = i.rd_m; rd_w = i.rd_w;
        wm = i.wm; ww = i.ww; pc = i.pc; mc_op = i.mc_op; done = i.done; rst_n = i.rst_n;
    endtask

    task automatic compare(input string name, input out_t exp);
        out_t got;
        got = '{fwd_a: fwd_a, fwd_b: fwd_b, stall_f: stall_f, stall_d: stall_d,
                stall_e: stall_e, flush_d: flush_d, flush_e: flush_e, flush_m: flush_m,
                start: start, busy: busy, timeout: timeout};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (fa,fb,sf,sd,se,fd,fe,fm,start,busy,to)",
                     name, got, exp);
        end
    endtask

    task automatic run_cycle(input string name, input in_t i, input out_t exp);
        @(negedge clk);
        apply(i);
        #2;
        compare(name, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tv[$];
        in_t  base, v, r;
        out_t z;

        base = '0;
        base.rst_n = 1'b1;
        z = ex(2'b00, 2'b00, 9'b000_000_000);

        // Hazard-looking inputs while reset is held: everything must read 0.
        v = base; v.rst_n = 1'b0; v.mc_op = 1'b1; v.pc = 1'b1;
        v.rd_m = 5'd5; v.wm = 1'b1; v.rs1_e = 5'd5;
        v.res_src = 2'b01; v.rd_e = 5'd7; v.rs2_d = 5'd7;
        apply(v);
        run_cycle("reset_state", v, z);

        tv.push_back('{"idle_zero", base, z});
        v = base; v.rd_m = 5'd5; v.wm = 1'b1; v.rd_w = 5'd5; v.ww = 1'b1; v.rs1_e = 5'd5;
        tv.push_back('{"fwd_m_prio", v, ex(2'b10, 2'b00, 9'b0)});
        v.wm = 1'b0;
        tv.push_back('{"fwd_w", v, ex(2'b01, 2'b00, 9'b0)});
        v = base; v.rd_m = 5'd0; v.wm = 1'b1; v.rd_w = 5'd0; v.ww = 1'b1; v.rs1_e = 5'd0;
        tv.push_back('{"fwd_x0", v, z});
        v = base; v.rd_m = 5'd0; v.wm = 1'b1; v.rd_w = 5'd5; v.ww = 1'b1; v.rs1_e = 5'd5;
        tv.push_back('{"fwd_rdm0_w", v, ex(2'b01, 2'b00, 9'b0)});
        v = base; v.rd_m = 5'd9; v.wm = 1'b1; v.rs2_e = 5'd9; v.rd_w = 5'd3; v.ww = 1'b1; v.rs1_e = 5'd3;
        tv.push_back('{"fwd_both", v, ex(2'b01, 2'b10, 9'b0)});
        v = base; v.rd_m = 5'd9; v.rs1_e = 5'd9; v.rd_w = 5'd9;
        tv.push_back('{"fwd_no_we", v, z});
        v = base; v.res_src = 2'b01; v.rd_e = 5'd7; v.rs2_d = 5'd7;
        tv.push_back('{"lu_rs2", v, ex(2'b00, 2'b00, 9'b110_010_000)});
        v.rs2_d = 5'd0; v.rs1_d = 5'd7;
        tv.push_back('{"lu_rs1", v, ex(2'b00, 2'b00, 9'b110_010_000)});
        v.res_src = 2'b00;
        tv.push_back('{"lu_not_load", v, z});
        v = base; v.res_src = 2'b01;
        tv.push_back('{"lu_rd0", v, z});
        v = base; v.pc = 1'b1;
        tv.push_back('{"branch", v, ex(2'b00, 2'b00, 9'b000_110_000)});
        v.res_src = 2'b01; v.rd_e = 5'd7; v.rs2_d = 5'd7;
        tv.push_back('{"branch_lu", v, ex(2'b00, 2'b00, 9'b100_110_000)});
        v = base; v.pc = 1'b1; v.mc_op = 1'b1;
        tv.push_back('{"mc_squashed", v, ex(2'b00, 2'b00, 9'b000_110_000)});

        foreach (tv[k]) run_cycle(tv[k].name, tv[k].vin, tv[k].vexp);

        // Load-use: one stall cycle, then the injected bubble clears it.
        v = base; v.res_src = 2'b01; v.rd_e = 5'd7; v.rs2_d = 5'd7;
        run_cycle("lu_seq_hit", v, ex(2'b00, 2'b00, 9'b110_010_000));
        v.res_src = 2'b00; v.rd_e = 5'd0;
        run_cycle("lu_seq_after", v, z);

        // Multi-cycle op finishing on the 11th busy cycle; branch/load noise ignored.
        v = base; v.mc_op = 1'b1;
        run_cycle("mc_start", v, ex(2'b00, 2'b00, 9'b111_001_100));
        v.pc = 1'b1; v.res_src = 2'b01; v.rd_e = 5'd7; v.rs1_d = 5'd7;
        for (int k = 1; k <= 10; k++) run_cycle("mc_busy_hold", v, ex(2'b00, 2'b00, 9'b111_001_010));
        v.done = 1'b1;
        run_cycle("mc_done_release", v, ex(2'b00, 2'b00, 9'b000_000_010));
        run_cycle("mc_back_idle", base, z);
        v = base; v.done = 1'b1;
        run_cycle("mc_done_in_idle", v, z);

        // Watchdog abort with no done.
        v = base; v.mc_op = 1'b1;
        run_cycle("to_start", v, ex(2'b00, 2'b00, 9'b111_001_100));
        for (int k = 1; k <= TB_TIMEOUT; k++) run_cycle("to_busy_hold", v, ex(2'b00, 2'b00, 9'b111_001_010));
        run_cycle("to_abort", v, ex(2'b00, 2'b00, 9'b000_001_010));
        run_cycle("to_flag", base, ex(2'b00, 2'b00, 9'b000_000_001));
        run_cycle("to_sticky", base, ex(2'b00, 2'b00, 9'b000_000_001));
        run_cycle("to_start2", v, ex(2'b00, 2'b00, 9'b111_001_101));
        v.done = 1'b1;
        run_cycle("to_done_first_busy", v, ex(2'b00, 2'b00, 9'b000_000_011));
        run_cycle("to_sticky2", base, ex(2'b00, 2'b00, 9'b000_000_001));

        // Reset mid-op: outputs drop before the next clock edge.
        v = base; v.mc_op = 1'b1;
        run_cycle("rst_seq_start", v, ex(2'b00, 2'b00, 9'b111_001_101));
        run_cycle("rst_seq_busy", v, ex(2'b00, 2'b00, 9'b111_001_011));
        v.rst_n = 1'b0; v.pc = 1'b1; v.res_src = 2'b01; v.rd_e = 5'd7; v.rs1_d = 5'd7;
        v.rd_m = 5'd5; v.wm = 1'b1; v.rs1_e = 5'd5;
        run_cycle("rst_async", v, z);
        run_cycle("rst_release", base, z);
        run_cycle("rst_no_start", base, z);

        m_busy_n = 0;
        m_to     = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            r = rand_in();
            @(negedge clk);
            apply(r);
            #2;
            compare($sformatf("rand%0d", k), model_eval(r));
            model_step(r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32_hazard_ctrl.md
Name: rv32_hazard_ctrl

Overview:
- Central pipeline hazard controller for the 5-stage RV32 core.
- Generates execute-stage forwarding selects, load-use stalls and branch/jump flushes.
- Sequences multi-cycle execute operations (M-extension divide/iterative multiply) through a start/done handshake with a timeout watchdog.
- Sits beside the datapath; consumes register indices and control bits from D/E/M/W, drives stall/flush enables of every pipeline register.

Parameters:
- MC_TIMEOUT, 64, maximum cycles a multi-cycle op may stay busy before abort; counter width $clog2(MC_TIMEOUT+1).
- LOAD_RESULT_SRC, 2'b01, result_source encoding identifying a load in E.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- rs1_d_i, rs2_d_i  in  5 each  source registers of the decode-stage instruction.
- rs1_e_i, rs2_e_i, rd_e_i  in  5 each  sources/destination of the execute-stage instruction.
- result_source_e_i  in  2  execute-stage result source.
- rd_m_i, rd_w_i  in  5 each  destinations in M and W.
- reg_write_m_i, reg_write_w_i  in  1 each  write enables in M and W.
- pc_source_e_i  in  1  taken branch/jump resolved in E.
- mc_op_e_i  in  1  execute-stage instruction is multi-cycle.
- mc_done_i  in  1  multi-cycle unit result valid (single-cycle pulse).
- forward_a_o, forward_b_o  out  2 each  00 register file, 01 W result, 10 M ALU result.
- stall_f_o, stall_d_o, stall_e_o  out  1 each  hold PC, F/D, D/E registers.
- flush_d_o, flush_e_o, flush_m_o  out  1 each  bubble into F/D, D/E, E/M registers.
- mc_start_o  out  1  single-cycle start pulse to the multi-cycle unit.
- mc_busy_o  out  1  FSM in BUSY.
- mc_timeout_o  out  1  sticky timeout flag.

Behaviour:
- Reset: FSM IDLE, counter 0, mc_timeout_o 0; all outputs 0.
- Forwarding (combinational, per source):
  - 10 if reg_write_m_i && rd_m_i!=0 && rd_m_i==rs*_e_i.
  - else 01 if reg_write_w_i && rd_w_i!=0 && rd_w_i==rs*_e_i.
  - else 00.
  - M has priority over W.
- Load-use: lw_stall = (result_source_e_i==LOAD_RESULT_SRC) && rd_e_i!=0 && (rd_e_i==rs1_d_i || rd_e_i==rs2_d_i).
  - Effect: stall_f, stall_d, flush_e asserted for exactly one cycle.
- Control hazard: pc_source_e_i asserts flush_d and flush_e in the same cycle. If lw_stall is also true, flush wins for D; stall_f is still asserted.
- FSM IDLE:
  - If mc_op_e_i && !pc_source_e_i: assert mc_start_o, load counter 0, go BUSY.
  - In that same cycle assert stall_f/d/e and flush_m; the instruction holds in E.
- FSM BUSY:
  - Each cycle the counter increments; stall_f/d/e and flush_m stay asserted; mc_start_o is 0.
  - On mc_done_i (including the first BUSY cycle): deassert all stalls and flush_m combinationally so the E/M register captures the result at that edge; go IDLE.
  - If the counter reaches MC_TIMEOUT without done: set mc_timeout_o (sticky until reset), release stalls for one cycle with flush_m held 1 (result discarded), go IDLE.
- While BUSY, lw_stall and pc_source_e_i are ignored; the multi-cycle instruction is not a branch.
- mc_done_i in IDLE is ignored. Reset mid-op returns to IDLE immediately with no start pulse.
- Fixed latency: forwarding and hazard outputs have 0-cycle latency; mc_start_o is the same cycle as detection. Minimum multi-cycle occupancy is 2 cycles.

Decomposition:
- rv32_pkg gains: forward select enum (FWD_RF, FWD_W, FWD_M), mc FSM state enum (MC_IDLE, MC_BUSY), LOAD_RESULT_SRC constant.
- No sub-module is required; the forwarding logic is a local function. Optional sub-module rv32_hazard_mc_fsm holds the FSM and timeout counter.

Test Plan:
- rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1, rs1_e=5 -> forward_a=10. Clear reg_write_m -> forward_a=01. Set rd_m=0 -> never 10.
- Load in E with rd_e=7, rs2_d=7 -> one cycle of stall_f=stall_d=flush_e=1, then all 0.
- pc_source_e=1 concurrent with lw_stall -> flush_d=flush_e=1, stall_f=1 in the same cycle.
- mc_op_e=1, mc_done after 10 cycles -> mc_start one pulse; stalls and flush_m high 11 cycles; released on the done cycle; mc_busy falls the next cycle.
- mc_op_e=1, no done -> after MC_TIMEOUT cycles mc_timeout_o=1 (sticky), one release cycle with flush_m=1, FSM IDLE.
- rst_n_i low during BUSY -> all outputs 0 asynchronously; after release no mc_start without a new mc_op_e.
